// File: rtl/port_wr_backend.sv
// -----------------------------------------------------------------------------
// port_wr_backend
//
// Write back-end of a switch input port. It packs the front-end's half-word
// transfer stream into SRAM pages of 2**OFS_W half-words, takes pages from a
// free-page allocator and chains them through the jump table. At the end of a
// packet it emits one descriptor (head page, tail page, dest port, length) to
// the port enqueue logic.
//
// The front-end cannot be back-pressured, so one spare page is always kept
// prefetched. A page crossing with no spare available truncates the packet:
// the remaining beats are discarded and the descriptor is flagged as a drop.
//
// Optional feature (macro PORT_WR_BACKEND_STAT_EN): adds the 16-bit wrapping
// counters stat_pkt_cnt and stat_drop_cnt. Without the macro these ports and
// their logic are absent.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   ready_to_xfer              front-end about to start a packet
//   xfer_data_vld/xfer_data    half-word beat
//   end_of_packet              marks the last beat (with xfer_data_vld)
//   alloc_req/alloc_vld/alloc_page   free-page allocator handshake
//   sram_wr_en/addr/data       packet SRAM write port, addr = {page, offset}
//   jt_wr_en/addr/data         jump-table write (current page -> next page)
//   desc_*                     packet descriptor, desc_vld/desc_drop 1-cycle
//   busy                       FSM not idle
//   stat_pkt_cnt/stat_drop_cnt (optional) descriptor and drop counters
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no packet in progress; a beat here is taken as the first beat
// RECV  | packet in progress, beats are written to SRAM
// DROP  | packet truncated, beats discarded until end_of_packet
// -----------------------------------------------------------------------------
module port_wr_backend #(
    parameter int PAGE_AW = 11,
    parameter int OFS_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ready_to_xfer,
    input  logic                     xfer_data_vld,
    input  logic [15:0]              xfer_data,
    input  logic                     end_of_packet,
    output logic                     alloc_req,
    input  logic                     alloc_vld,
    input  logic [PAGE_AW-1:0]       alloc_page,
    output logic                     sram_wr_en,
    output logic [PAGE_AW+OFS_W-1:0] sram_wr_addr,
    output logic [15:0]              sram_wr_data,
    output logic                     jt_wr_en,
    output logic [PAGE_AW-1:0]       jt_wr_addr,
    output logic [PAGE_AW-1:0]       jt_wr_data,
    output logic                     desc_vld,
    output logic [PAGE_AW-1:0]       desc_head,
    output logic [PAGE_AW-1:0]       desc_tail,
    output logic [3:0]               desc_dest,
    output logic [8:0]               desc_len,
    output logic                     desc_drop,
    output logic                     busy
`ifdef PORT_WR_BACKEND_STAT_EN
    ,
    output logic [15:0]              stat_pkt_cnt,
    output logic [15:0]              stat_drop_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state;
    logic               started;     // first beat of the packet already taken
    logic               spare_vld;
    logic [PAGE_AW-1:0] spare_page;
    logic [PAGE_AW-1:0] cur_page;
    logic [PAGE_AW-1:0] head_page;
    logic [OFS_W-1:0]   offset;
    logic [8:0]         len;
    logic [3:0]         dest;

    logic               first_beat;
    logic               cont_beat;
    logic               drop_end;
    logic               last_ofs;
    logic               consume;
    logic [8:0]         len_inc;

    assign alloc_req = ~spare_vld;
    assign busy      = (state != IDLE);

    always_comb begin
        first_beat = xfer_data_vld && ((state == IDLE) || ((state == RECV) && !started));
        cont_beat  = xfer_data_vld && (state == RECV) && started;
        drop_end   = xfer_data_vld && end_of_packet && (state == DROP);
        last_ofs   = &offset;
        // an end_of_packet beat on the last offset never pre-links a page
        consume    = spare_vld && (first_beat || (cont_beat && last_ofs && !end_of_packet));
        len_inc    = (&len) ? len : len + 9'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            started      <= 1'b0;
            spare_vld    <= 1'b0;
            spare_page   <= '0;
            cur_page     <= '0;
            head_page    <= '0;
            offset       <= '0;
            len          <= '0;
            dest         <= '0;
            sram_wr_en   <= 1'b0;
            sram_wr_addr <= '0;
            sram_wr_data <= '0;
            jt_wr_en     <= 1'b0;
            jt_wr_addr   <= '0;
            jt_wr_data   <= '0;
            desc_vld     <= 1'b0;
            desc_head    <= '0;
            desc_tail    <= '0;
            desc_dest    <= '0;
            desc_len     <= '0;
            desc_drop    <= 1'b0;
        end else begin
            sram_wr_en <= 1'b0;
            jt_wr_en   <= 1'b0;
            desc_vld   <= 1'b0;
            desc_drop  <= 1'b0;

            // a grant only arrives while no spare is held, so it can never
            // collide with a consumption in the same cycle
            if (alloc_vld) begin
                spare_vld  <= 1'b1;
                spare_page <= alloc_page;
            end else if (consume) begin
                spare_vld  <= 1'b0;
            end

            if (first_beat) begin
                dest    <= xfer_data[3:0];
                started <= 1'b1;
                if (spare_vld) begin
                    sram_wr_en   <= 1'b1;
                    sram_wr_addr <= {spare_page, {OFS_W{1'b0}}};
                    sram_wr_data <= xfer_data;
                    cur_page     <= spare_page;
                    head_page    <= spare_page;
                    offset       <= OFS_W'(1);
                    len          <= 9'd1;
                    if (end_of_packet) begin
                        desc_vld  <= 1'b1;
                        desc_head <= spare_page;
                        desc_tail <= spare_page;
                        desc_dest <= xfer_data[3:0];
                        desc_len  <= 9'd1;
                        state     <= IDLE;
                    end else begin
                        state     <= RECV;
                    end
                end else begin
                    cur_page  <= '0;
                    head_page <= '0;
                    offset    <= '0;
                    len       <= '0;
                    if (end_of_packet) begin
                        desc_vld  <= 1'b1;
                        desc_drop <= 1'b1;
                        desc_head <= '0;
                        desc_tail <= '0;
                        desc_dest <= xfer_data[3:0];
                        desc_len  <= '0;
                        state     <= IDLE;
                    end else begin
                        state     <= DROP;
                    end
                end
            end else if (cont_beat) begin
                sram_wr_en   <= 1'b1;
                sram_wr_addr <= {cur_page, offset};
                sram_wr_data <= xfer_data;
                offset       <= offset + OFS_W'(1);
                len          <= len_inc;
                if (end_of_packet) begin
                    desc_vld  <= 1'b1;
                    desc_head <= head_page;
                    desc_tail <= cur_page;
                    desc_dest <= dest;
                    desc_len  <= len_inc;
                    state     <= IDLE;
                end else if (last_ofs) begin
                    if (spare_vld) begin
                        jt_wr_en   <= 1'b1;
                        jt_wr_addr <= cur_page;
                        jt_wr_data <= spare_page;
                        cur_page   <= spare_page;
                    end else begin
                        state      <= DROP;
                    end
                end
            end else if (drop_end) begin
                desc_vld  <= 1'b1;
                desc_drop <= 1'b1;
                desc_head <= head_page;
                desc_tail <= cur_page;
                desc_dest <= dest;
                desc_len  <= len;
                state     <= IDLE;
            end else if ((state == IDLE) && ready_to_xfer) begin
                started <= 1'b0;
                state   <= RECV;
            end
        end
    end

`ifdef PORT_WR_BACKEND_STAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_pkt_cnt  <= '0;
            stat_drop_cnt <= '0;
        end else if (desc_vld) begin
            stat_pkt_cnt <= stat_pkt_cnt + 16'd1;
            if (desc_drop) begin
                stat_drop_cnt <= stat_drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_port_wr_backend.sv
// -----------------------------------------------------------------------------
// tb_port_wr_backend
//
// Directed bench for port_wr_backend. Inputs are driven on the falling edge,
// outputs are logged on the falling edge, and a queue-fed allocator answers
// alloc_req with one grant per request.
// -----------------------------------------------------------------------------
module tb_port_wr_backend;

    typedef struct packed {
        logic [10:0] head;
        logic [10:0] tail;
        logic [3:0]  dest;
        logic [8:0]  len;
        logic        drop;
    } desc_t;

    logic        clk;
    logic        rst_n;
    logic        ready_to_xfer;
    logic        xfer_data_vld;
    logic [15:0] xfer_data;
    logic        end_of_packet;
    logic        alloc_req;
    logic        alloc_vld;
    logic [10:0] alloc_page;
    logic        sram_wr_en;
    logic [13:0] sram_wr_addr;
    logic [15:0] sram_wr_data;
    logic        jt_wr_en;
    logic [10:0] jt_wr_addr;
    logic [10:0] jt_wr_data;
    logic        desc_vld;
    logic [10:0] desc_head;
    logic [10:0] desc_tail;
    logic [3:0]  desc_dest;
    logic [8:0]  desc_len;
    logic        desc_drop;
    logic        busy;

    int n_chk;
    int n_pass;

    logic [10:0] page_q[$];
    logic [13:0] wa_q[$];
    logic [15:0] wd_q[$];
    logic [21:0] jt_q[$];
    desc_t       desc_q[$];

    port_wr_backend #(.PAGE_AW(11), .OFS_W(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ready_to_xfer (ready_to_xfer),
        .xfer_data_vld (xfer_data_vld),
        .xfer_data     (xfer_data),
        .end_of_packet (end_of_packet),
        .alloc_req     (alloc_req),
        .alloc_vld     (alloc_vld),
        .alloc_page    (alloc_page),
        .sram_wr_en    (sram_wr_en),
        .sram_wr_addr  (sram_wr_addr),
        .sram_wr_data  (sram_wr_data),
        .jt_wr_en      (jt_wr_en),
        .jt_wr_addr    (jt_wr_addr),
        .jt_wr_data    (jt_wr_data),
        .desc_vld      (desc_vld),
        .desc_head     (desc_head),
        .desc_tail     (desc_tail),
        .desc_dest     (desc_dest),
        .desc_len      (desc_len),
        .desc_drop     (desc_drop),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // allocator: one grant per request while pages are queued
    always @(negedge clk) begin
        if (rst_n && alloc_req && (page_q.size() > 0)) begin
            alloc_vld  = 1'b1;
            alloc_page = page_q.pop_front();
        end else begin
            alloc_vld  = 1'b0;
            alloc_page = '0;
        end
    end

    // output logger
    always @(negedge clk) begin
        if (sram_wr_en) begin
            wa_q.push_back(sram_wr_addr);
            wd_q.push_back(sram_wr_data);
        end
        if (jt_wr_en) jt_q.push_back({jt_wr_addr, jt_wr_data});
        if (desc_vld) begin
            desc_q.push_back({desc_head, desc_tail, desc_dest, desc_len, desc_drop});
            // a clean descriptor shares its cycle with the last SRAM write
            if (!desc_drop) check("desc_with_last_wr", {31'd0, sram_wr_en}, 32'd1);
        end
    end

    task automatic clear_logs();
        wa_q.delete();
        wd_q.delete();
        jt_q.delete();
        desc_q.delete();
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            ready_to_xfer = 1'b0;
            xfer_data_vld = 1'b0;
            xfer_data     = '0;
            end_of_packet = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ready_to_xfer = 1'b0;
        xfer_data_vld = 1'b0;
        xfer_data     = '0;
        end_of_packet = 1'b0;
        page_q.delete();
        repeat (2) @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
    endtask

    // lead=1: ready_to_xfer alone one cycle ahead; lead=0: with the first beat
    task automatic send_pkt(input int n, input logic [15:0] hw, input bit lead, input bit chk_busy);
        if (lead) begin
            @(negedge clk);
            ready_to_xfer = 1'b1;
            xfer_data_vld = 1'b0;
            end_of_packet = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (chk_busy && i > 0) check("busy_in_pkt", {31'd0, busy}, 32'd1);
            ready_to_xfer = (!lead && i == 0);
            xfer_data_vld = 1'b1;
            xfer_data     = hw + 16'(i);
            end_of_packet = (i == n - 1);
        end
    endtask

    task automatic chk_writes(input string tag, input int n, input logic [13:0] a0, input logic [15:0] d0);
        check({tag, "_wr_cnt"}, wa_q.size(), n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_wr_addr"}, (i < wa_q.size()) ? {18'd0, wa_q[i]} : 32'hDEAD, {18'd0, a0 + 14'(i)});
            check({tag, "_wr_data"}, (i < wd_q.size()) ? {16'd0, wd_q[i]} : 32'hDEAD, {16'd0, d0 + 16'(i)});
        end
    endtask

    task automatic chk_desc(input string tag, input int idx, input logic [10:0] head, input logic [10:0] tail,
                            input logic [3:0] dest, input logic [8:0] len, input logic drop);
        desc_t d;
        check({tag, "_desc_present"}, {31'd0, desc_q.size() > idx}, 32'd1);
        d = (desc_q.size() > idx) ? desc_q[idx] : '1;
        check({tag, "_head"}, {21'd0, d.head}, {21'd0, head});
        check({tag, "_tail"}, {21'd0, d.tail}, {21'd0, tail});
        check({tag, "_dest"}, {28'd0, d.dest}, {28'd0, dest});
        check({tag, "_len"},  {23'd0, d.len},  {23'd0, len});
        check({tag, "_drop"}, {31'd0, d.drop}, {31'd0, drop});
    endtask

    task automatic chk_idle_outputs(input string tag);
        check({tag, "_sram_wr_en"},   {31'd0, sram_wr_en}, 32'd0);
        check({tag, "_sram_wr_addr"}, {18'd0, sram_wr_addr}, 32'd0);
        check({tag, "_sram_wr_data"}, {16'd0, sram_wr_data}, 32'd0);
        check({tag, "_jt_wr_en"},     {31'd0, jt_wr_en}, 32'd0);
        check({tag, "_jt_wr_addr"},   {21'd0, jt_wr_addr}, 32'd0);
        check({tag, "_desc_vld"},     {31'd0, desc_vld}, 32'd0);
        check({tag, "_desc_drop"},    {31'd0, desc_drop}, 32'd0);
        check({tag, "_desc_len"},     {23'd0, desc_len}, 32'd0);
        check({tag, "_busy"},         {31'd0, busy}, 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        ready_to_xfer = 1'b0;
        xfer_data_vld = 1'b0;
        xfer_data     = '0;
        end_of_packet = 1'b0;
        alloc_vld     = 1'b0;
        alloc_page    = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk_idle_outputs("rst");
        check("rst_alloc_req", {31'd0, alloc_req}, 32'd1);

        // 5-beat packet on page 0x010
        do_reset();
        page_q = '{11'h010, 11'h099};
        send_pkt(5, 16'h0283, 1'b1, 1'b0);
        idle(5);
        chk_writes("p5", 5, 14'h080, 16'h0283);
        check("p5_jt_cnt", jt_q.size(), 0);
        check("p5_desc_cnt", desc_q.size(), 1);
        chk_desc("p5", 0, 11'h010, 11'h010, 4'd3, 9'd5, 1'b0);

        // 8-beat packet ending on offset 7
        do_reset();
        page_q = '{11'h020};
        send_pkt(8, 16'h1235, 1'b1, 1'b0);
        idle(5);
        chk_writes("p8", 8, 14'h100, 16'h1235);
        check("p8_jt_cnt", jt_q.size(), 0);
        chk_desc("p8", 0, 11'h020, 11'h020, 4'd5, 9'd8, 1'b0);

        // no spare left for the first beat: drop with zero length
        clear_logs();
        send_pkt(2, 16'h0046, 1'b1, 1'b0);
        idle(5);
        check("nospare_wr_cnt", wa_q.size(), 0);
        chk_desc("nospare", 0, 11'h000, 11'h000, 4'd6, 9'd0, 1'b1);

        // 20-beat packet over three pages
        do_reset();
        page_q = '{11'h001, 11'h002, 11'h003};
        send_pkt(20, 16'h00A7, 1'b1, 1'b0);
        idle(5);
        check("p20_wr_cnt", wa_q.size(), 20);
        for (int i = 0; i < 20; i++) begin
            check("p20_wr_addr", (i < wa_q.size()) ? {18'd0, wa_q[i]} : 32'hDEAD,
                  32'((1 + i / 8) * 8 + (i % 8)));
        end
        check("p20_last_addr", (wa_q.size() > 0) ? {18'd0, wa_q[wa_q.size()-1]} : 32'hDEAD, 32'h01B);
        check("p20_jt_cnt", jt_q.size(), 2);
        check("p20_jt0", (jt_q.size() > 0) ? {10'd0, jt_q[0]} : 32'hDEAD, {10'd0, 11'h001, 11'h002});
        check("p20_jt1", (jt_q.size() > 1) ? {10'd0, jt_q[1]} : 32'hDEAD, {10'd0, 11'h002, 11'h003});
        chk_desc("p20", 0, 11'h001, 11'h003, 4'd7, 9'd20, 1'b0);

        // allocator withholds the second page: truncated after 8 beats
        do_reset();
        page_q = '{11'h040};
        send_pkt(12, 16'h000C, 1'b1, 1'b1);
        idle(5);
        chk_writes("trunc", 8, 14'h200, 16'h000C);
        check("trunc_jt_cnt", jt_q.size(), 0);
        chk_desc("trunc", 0, 11'h040, 11'h040, 4'hC, 9'd8, 1'b1);
        check("trunc_busy_after", {31'd0, busy}, 32'd0);

        // back-to-back packets, second uses the prefetched spare
        do_reset();
        page_q = '{11'h050, 11'h051, 11'h052};
        send_pkt(3, 16'h0011, 1'b1, 1'b0);
        send_pkt(2, 16'h0F02, 1'b0, 1'b0);
        idle(5);
        check("b2b_wr_cnt", wa_q.size(), 5);
        check("b2b_wr_a2", (wa_q.size() > 2) ? {18'd0, wa_q[2]} : 32'hDEAD, 32'h282);
        check("b2b_wr_a3", (wa_q.size() > 3) ? {18'd0, wa_q[3]} : 32'hDEAD, 32'h288);
        check("b2b_wr_d4", (wd_q.size() > 4) ? {16'd0, wd_q[4]} : 32'hDEAD, 32'h0F03);
        check("b2b_desc_cnt", desc_q.size(), 2);
        chk_desc("b2b_a", 0, 11'h050, 11'h050, 4'd1, 9'd3, 1'b0);
        chk_desc("b2b_b", 1, 11'h051, 11'h051, 4'd2, 9'd2, 1'b0);

        // reset mid-packet after 3 beats, then a single-beat packet
        do_reset();
        page_q = '{11'h060, 11'h061};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ready_to_xfer = 1'b0;
            xfer_data_vld = 1'b1;
            xfer_data     = 16'h0008 + 16'(i);
            end_of_packet = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        xfer_data_vld = 1'b0;
        xfer_data     = '0;
        page_q.delete();
        @(negedge clk);
        chk_idle_outputs("midrst");
        check("midrst_alloc_req", {31'd0, alloc_req}, 32'd1);
        rst_n = 1'b1;
        clear_logs();
        page_q = '{11'h070};
        idle(3);
        send_pkt(1, 16'h0004, 1'b1, 1'b0);
        idle(5);
        chk_writes("single", 1, 14'h380, 16'h0004);
        chk_desc("single", 0, 11'h070, 11'h070, 4'd4, 9'd1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
